barrel_shift_right_pipe: RTL and testbench

BARREL_SHIFT_RIGHT_PIPE -- requirements
Module: barrel_shift_right_pipe

---
 rtl/barrel_shift_right_pipe.sv | 115 +++++++++++
 tb/tb_barrel_shift_right_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_right_pipe.sv
// Pipelined barrel shifter (LSR/ASR/ROR/LSL) with a valid/ready handshake.
// Stage i applies a 2^i step when its shift bit is set; the whole pipe stalls as one unit.
module barrel_shift_right_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shift,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NS = SHW;

  typedef enum logic [1:0] {
    OpLsr = 2'b00,
    OpAsr = 2'b01,
    OpRor = 2'b10,
    OpLsl = 2'b11
  } op_e;

  // Stage i forwards only the shift bits later stages still need (SHW-1-i bits),
  // packed back to back; this gives the bit offset of stage i's slice.
  function automatic int rem_off(input int i);
    return i * (int'(SHW) - 1) - (i * (i - 1)) / 2;
  endfunction

  localparam int RemBits = rem_off(int'(NS) - 1);

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       o,
                                                  input int unsigned      amt);
    logic [WIDTH-1:0] r;
    case (op_e'(o))
      OpLsr:   r = d >> amt;
      // MSB of every intermediate ASR value is still the original sign bit.
      OpAsr:   r = $signed(d) >>> amt;
      OpRor:   r = (d >> amt) | (d << (WIDTH - amt));
      default: r = d << amt;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]   data_q [NS];
  logic [WIDTH-1:0]   data_d [NS];
  logic [NS-1:0]      valid_q, valid_d;
  logic [1:0]         op_q   [NS-1];
  logic [1:0]         op_d   [NS-1];
  logic [RemBits-1:0] rem_q, rem_d;
  logic               adv;

  assign adv       = !valid_q[NS-1] || out_ready;
  assign in_ready  = adv;
  assign out       = data_q[NS-1];
  assign out_valid = valid_q[NS-1];

  for (genvar i = 0; i < NS; i++) begin : g_stage
    localparam int unsigned RemW = SHW - i;
    localparam int unsigned Amt  = 1 << i;

    logic [WIDTH-1:0] src_data;
    logic [1:0]       src_op;
    logic [RemW-1:0]  src_rem;
    logic             src_valid;

    if (i == 0) begin : g_first
      assign src_data  = in;
      assign src_op    = op;
      assign src_rem   = shift;
      assign src_valid = in_valid;
    end else begin : g_next
      assign src_data  = data_q[i-1];
      assign src_op    = op_q[i-1];
      assign src_rem   = rem_q[rem_off(i-1) +: RemW];
      assign src_valid = valid_q[i-1];
    end

    assign data_d[i]  = src_rem[0] ? shift_step(src_data, src_op, Amt) : src_data;
    assign valid_d[i] = src_valid;

    if (i < NS - 1) begin : g_carry
      assign op_d[i]                       = src_op;
      assign rem_d[rem_off(i) +: RemW - 1] = src_rem[RemW-1:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NS); k++) data_q[k] <= '0;
      for (int k = 0; k < int'(NS) - 1; k++) op_q[k] <= '0;
      rem_q   <= '0;
      valid_q <= '0;
    end else begin
      if (adv) begin
        data_q <= data_d;
        op_q   <= op_d;
        rem_q  <= rem_d;
      end
      // Flush only kills valid bits; stale data behind them is harmless.
      if (flush) begin
        valid_q <= '0;
      end else if (adv) begin
        valid_q <= valid_d;
      end
    end
  end

endmodule

// File: tb/tb_barrel_shift_right_pipe.sv
// Bench for barrel_shift_right_pipe: directed literal cases plus randomized traffic
// checked against a whole-amount shift model and an in-order queue of expected results.
module tb_barrel_shift_right_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready, in_ready, out_valid;
  logic [15:0] din, dout;
  logic [3:0]  shift;
  logic [1:0]  op;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [15:0] q[$];
  logic        prev_hold = 1'b0;
  logic [15:0] prev_out  = '0;

  barrel_shift_right_pipe #(.WIDTH(16), .SHW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in       (din),
    .shift    (shift),
    .op       (op),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (dout),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] x, input int s,
                                            input logic [1:0] o);
    logic [15:0] r;
    case (o)
      2'd0:    r = x >> s;
      2'd1:    r = $signed(x) >>> s;
      2'd2:    r = (x >> s) | (x << (16 - s));
      default: r = x << s;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] s,
                       input logic [1:0] o);
    in_valid = v;
    din      = d;
    shift    = s;
    op       = o;
  endtask

  // Scoreboard: in-order queue of results owed by the pipe, checked at each negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_hold = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_hold) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_data_held", dout, prev_out);
      end
      if (out_valid) begin
        chk("output_expected", q.size() > 0, 1);
        if (out_ready && q.size() > 0) chk("result", dout, q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back(ref_shift(din, int'(shift), op));
        n_acc++;
      end
      if (q.size() > 4) chk("inflight_max4", q.size(), 4);
      prev_hold = out_valid && !out_ready && !flush;
      prev_out  = dout;
    end
  end

  logic [15:0] d36 [4] = '{16'hFFFF, 16'h8001, 16'h0001, 16'h1234};
  logic [3:0]  s36 [4] = '{4'd15, 4'd1, 4'd15, 4'd0};
  logic [1:0]  o36 [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
  logic [15:0] e36 [4] = '{16'h0001, 16'hC000, 16'h8000, 16'h1234};
  logic [15:0] d37 [4] = '{16'hA5F0, 16'h8F00, 16'h0F0F, 16'h7001};
  logic [3:0]  s37 [4] = '{4'd3, 4'd7, 4'd4, 4'd12};
  logic [1:0]  o37 [4] = '{2'd1, 2'd1, 2'd2, 2'd3};

  initial begin
    int start;
    int cycles;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    #2;
    chk("reset_out", dout, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    tick; tick;
    rst_n = 1'b1;

    // ASR latency, accepted on first edge after reset release
    out_ready = 1'b1;
    drive(1'b1, 16'h8000, 4'd4, 2'd1);
    tick;
    in_valid = 1'b0;
    tick; tick;
    chk("asr_not_early", out_valid, 0);
    tick;
    chk("asr_valid", out_valid, 1);
    chk("asr_data", dout, 16'hF800);
    tick;

    // Back-to-back literal vectors
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, d36[j], s36[j], o36[j]);
      tick;
    end
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("b2b_valid", out_valid, 1);
      chk("b2b_data", dout, e36[j]);
      tick;
    end
    chk("b2b_drained", out_valid, 0);

    // Stall with four in flight
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, d37[j], s37[j], o37[j]);
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stall_first", dout, ref_shift(d37[0], int'(s37[0]), o37[0]));
    repeat (3) begin
      tick;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", dout, ref_shift(d37[0], int'(s37[0]), o37[0]));
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick;
      chk("release_valid", out_valid, 1);
      chk("release_data", dout, ref_shift(d37[j], int'(s37[j]), o37[j]));
    end
    tick;
    chk("release_no_dup", out_valid, 0);

    // Flush with three valid stages; vector presented alongside flush is dropped
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, d37[j], s37[j], o37[j]);
      tick;
    end
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(1'b1, 16'hBEEF, 4'd2, 2'd0);
    #1;
    chk("flush_in_ready", in_ready, 1);
    tick;
    chk("flush_cleared", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      tick;
      chk("flush_nothing_out", out_valid, 0);
    end

    // Reset with four valid stages
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, d36[j], s36[j], o36[j]);
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out", dout, 0);
    chk("midreset_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    tick; tick;
    rst_n = 1'b1;
    drive(1'b1, 16'hF000, 4'd8, 2'd1);
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    tick;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick; tick;
    chk("post_reset_not_early", out_valid, 0);
    tick;
    chk("post_reset_valid", out_valid, 1);
    chk("post_reset_data", dout, 16'hFFF0);
    tick;
    chk("post_reset_no_stale", out_valid, 0);

    // Randomized traffic
    start  = n_acc;
    cycles = 0;
    while (n_acc - start < 10000 && cycles < 60000) begin
      drive($urandom_range(0, 9) < 8, 16'($urandom), 4'($urandom), 2'($urandom));
      out_ready = $urandom_range(0, 9) < 6;
      flush     = $urandom_range(0, 299) == 0;
      tick;
      cycles++;
    end
    chk("random_transfer_count", n_acc - start >= 10000, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick;
    chk("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
